text_buffer: RTL and testbench
==============================

# text_buffer

Character tile map for the 8x8 font text display: stores a 40x30 grid of 7-bit character codes and accepts a byte stream with a cursor and control codes. Scans the grid at the halved VGA pixel coordinates and returns the character code plus in-glyph row and column to the font tile renderer directly downstream. It runs in the 25 MHz pixel clock domain, alongside the VGA timing controller.

## Interface
- COLS, 40, characters per row (320 px / 8)
- ROWS, 30, character rows (240 px / 8)
- BLINK_W, 23, cursor blink counter width; blink phase = counter MSB
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  reset; one clock, reset is synchronous and active-high
- in_valid  in  1  input byte valid
- in_char  in  8  input byte (ASCII)
- in_ready  out  1  byte accepted on a clock edge where in_valid && in_ready
- pixel_x  in  10  horizontal coordinate (h_cnt>>1), 0..319 valid
- pixel_y  in  10  vertical coordinate (v_cnt>>1), 0..239 valid
- char_code  out  7  registered character at (pixel_x, pixel_y)
- glyph_row  out  3  pixel_y[2:0], delayed 1 cycle
- glyph_col  out  3  pixel_x[2:0], delayed 1 cycle
- cursor_hit  out  1  registered; current cell is the cursor and blink phase is on
- cursor_col  out  6  cursor column 0..COLS-1
- cursor_row  out  5  cursor row 0..ROWS-1
- busy  out  1  clear in progress

## Operation
- Storage: COLS*ROWS (1200) entries x 7 bits, one write port, one read port; address = row*COLS + col.
- FSM states: CLEAR and IDLE.
- CLEAR: writes 0x20 to address clr_addr, one cell per cycle, 0..1199. busy=1, in_ready=0. After the write at 1199 -> IDLE.
- IDLE: busy=0, in_ready=1. At most one byte is accepted per cycle, with no back-pressure.
- Accepted byte handling:
  - 0x20..0x7E: write in_char[6:0] at the cursor; col+1. If col was COLS-1: col=0, row+1.
  - 0x0A (LF): col=0, row+1.
  - 0x0D (CR): col=0.
  - 0x08 (BS): if col>0, col-1 and write 0x20 at the new position. If col=0, no effect.
  - 0x0C (FF): cursor to (0,0), enter CLEAR, clr_addr=0.
  - Any other byte: accepted, no effect.
- Row increment from ROWS-1 wraps to 0. There is no scrolling.
- Read path:
  - cell = (pixel_y>>3, pixel_x>>3).
  - If pixel_x>=320 or pixel_y>=240: char_code=0x20 and cursor_hit=0.
  - Otherwise char_code = the stored code.
- Read-during-write to the same cell: read returns the old value (read-first).
- cursor_hit = 1 when all hold: state==IDLE, blink MSB=1, in-range cell equals the cursor.
- Blink counter: free-running, increments every cycle, cleared by rst only. Period 2^23 cycles ≈ 0.34 s at 25 MHz.

## Timing
- Reset values:
  - state=CLEAR, clr_addr=0, busy=1, in_ready=0
  - cursor (0,0)
  - char_code=0x20, glyph_row=0, glyph_col=0, cursor_hit=0
  - blink counter 0
- Clear timing:
  - With rst sampled high at edge 0, the clear writes occur at edges 1..1200.
  - From edge 1200: busy=0, in_ready=1.
  - rst during CLEAR or IDLE restarts the full clear; a byte presented with rst high is dropped.
- Write latency: byte accepted at edge t. Memory and cursor outputs are updated at edge t. A read issued after edge t sees the new code.
- Form feed accepted at edge t:
  - in_ready=0 and busy=1 from edge t.
  - Clear writes occur at edges t+1..t+1200.
  - in_ready=1 from edge t+1200.
- Read latency: exactly 1 cycle from pixel_x/pixel_y to char_code, glyph_row, glyph_col and cursor_hit, all aligned.
- Arithmetic: row*COLS is computed on an 11-bit address. The 6-bit col and 5-bit row never exceed COLS-1 and ROWS-1.

## Test plan
- Reset, then hold in_valid=0:
  - busy=1 and in_ready=0 for 1200 cycles, then in_ready=1.
  - Sweep pixels: every in-range char_code is 0x20.
  - pixel_x=320 yields 0x20.
- After clear, send "AB" (0x41, 0x42) on consecutive cycles:
  - pixel (0,0) -> char_code 0x41; pixel (8,0) -> char_code 0x42, one cycle after each coordinate.
  - cursor=(2,0).
  - glyph_col=5 for pixel_x=13.
- Send 40 printable bytes:
  - cursor goes (39,0) -> (0,1).
  - Continue with LF x29: cursor row wraps to 0.
  - Send BS at col 0: no change.
  - Send 'X', BS: cell (0,0) reads 0x20 and cursor=(0,0).
- Send FF mid-stream:
  - in_ready low for exactly 1200 cycles.
  - All cells read 0x20 afterwards; cursor=(0,0).
  - rst asserted at clear cycle 600: the clear restarts and completes 1200 cycles after rst release.
- Cursor blink, with cursor at (3,2):
  - pixel (24..31, 16..23): cursor_hit follows the blink counter MSB.
  - cursor_hit=0 at all other cells and during CLEAR.
  - Simultaneous write and read of the same cell returns the old code for that read.

Source files
------------

// File: rtl/text_buffer_if.sv
// Byte-stream input channel for the text tile map.
// Master drives bytes; slave accepts when in_valid && in_ready.
interface text_buffer_if;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_char,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_char,
        output in_ready
    );
endinterface

// File: rtl/text_buffer.sv
// 40x30 character tile map: byte stream with cursor and control codes on the write side,
// one-cycle scan lookup at halved VGA coordinates on the read side.
module text_buffer #(
    parameter int unsigned COLS    = 40,
    parameter int unsigned ROWS    = 30,
    parameter int unsigned BLINK_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    text_buffer_if.slave      bus,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic [6:0]        char_code,
    output logic [2:0]        glyph_row,
    output logic [2:0]        glyph_col,
    output logic              cursor_hit,
    output logic [5:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);

    localparam int unsigned Cells    = COLS * ROWS;
    localparam logic [10:0] LastAddr = 11'(Cells - 1);
    localparam logic [5:0]  LastCol  = 6'(COLS - 1);
    localparam logic [4:0]  LastRow  = 5'(ROWS - 1);
    localparam logic [6:0]  Space    = 7'h20;

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e              state_q, state_d;
    logic [10:0]         clr_addr_q, clr_addr_d;
    logic [5:0]          col_q, col_d;
    logic [4:0]          row_q, row_d;
    logic [BLINK_W-1:0]  blink_q;

    logic [6:0]          mem [Cells];
    logic                we;
    logic [10:0]         waddr;
    logic [6:0]          wdata;

    logic [6:0]          rd_col;
    logic [6:0]          rd_row;
    logic                in_range;
    logic                on_cursor;
    logic [10:0]         rd_addr;
    logic [6:0]          rd_data_q;
    logic                in_range_q;
    logic [2:0]          glyph_row_q, glyph_col_q;
    logic                cursor_hit_q;

    logic [4:0]          next_row;
    logic                printable;

    function automatic logic [10:0] cell_addr(input logic [4:0] r, input logic [5:0] c);
        return 11'(r) * 11'(COLS) + 11'(c);
    endfunction

    assign next_row  = (row_q == LastRow) ? 5'd0 : row_q + 5'd1;
    assign printable = (bus.in_char >= 8'h20) && (bus.in_char <= 8'h7e);

    // Write side: clear sweep or byte handling, exactly one memory write per cycle at most.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        col_d      = col_q;
        row_d      = row_q;
        we         = 1'b0;
        waddr      = clr_addr_q;
        wdata      = Space;
        unique case (state_q)
            StClear: begin
                we         = 1'b1;
                clr_addr_d = clr_addr_q + 11'd1;
                if (clr_addr_q == LastAddr) begin
                    state_d    = StIdle;
                    clr_addr_d = '0;
                end
            end
            StIdle: begin
                if (bus.in_valid) begin
                    if (printable) begin
                        we    = 1'b1;
                        waddr = cell_addr(row_q, col_q);
                        wdata = bus.in_char[6:0];
                        if (col_q == LastCol) begin
                            col_d = '0;
                            row_d = next_row;
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end else begin
                        case (bus.in_char)
                            8'h0a: begin
                                col_d = '0;
                                row_d = next_row;
                            end
                            8'h0d: col_d = '0;
                            8'h08: begin
                                if (col_q != '0) begin
                                    col_d = col_q - 6'd1;
                                    we    = 1'b1;
                                    waddr = cell_addr(row_q, col_q - 6'd1);
                                end
                            end
                            8'h0c: begin
                                col_d      = '0;
                                row_d      = '0;
                                clr_addr_d = '0;
                                state_d    = StClear;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            blink_q    <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            blink_q    <= blink_q + 1'b1;
        end
    end

    // Read side: cell lookup from the scan position.
    assign rd_col    = pixel_x[9:3];
    assign rd_row    = pixel_y[9:3];
    assign in_range  = (pixel_x < 10'(COLS * 8)) && (pixel_y < 10'(ROWS * 8));
    assign rd_addr   = in_range ? cell_addr(rd_row[4:0], rd_col[5:0]) : '0;
    assign on_cursor = in_range && (rd_col == {1'b0, col_q}) && (rd_row == {2'b00, row_q});

    // Read and write in one process so a same-cell collision returns the old code.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[waddr] <= wdata;
        end
        rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_range_q   <= 1'b0;
            glyph_row_q  <= '0;
            glyph_col_q  <= '0;
            cursor_hit_q <= 1'b0;
        end else begin
            in_range_q   <= in_range;
            glyph_row_q  <= pixel_y[2:0];
            glyph_col_q  <= pixel_x[2:0];
            cursor_hit_q <= (state_q == StIdle) && blink_q[BLINK_W-1] && on_cursor;
        end
    end

    assign char_code    = in_range_q ? rd_data_q : Space;
    assign glyph_row    = glyph_row_q;
    assign glyph_col    = glyph_col_q;
    assign cursor_hit   = cursor_hit_q;
    assign cursor_col   = col_q;
    assign cursor_row   = row_q;
    assign busy         = (state_q == StClear);
    assign bus.in_ready = (state_q == StIdle);

endmodule

// File: tb/tb_text_buffer.sv
// Bench for text_buffer: directed bytes and pixel probes; probes push expected read results
// into a scoreboard that a separate monitor drains one cycle later.
module tb_text_buffer;

    localparam int BW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic [6:0] char_code;
    logic [2:0] glyph_row, glyph_col;
    logic       cursor_hit;
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    text_buffer_if bus ();

    text_buffer #(.COLS(40), .ROWS(30), .BLINK_W(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .char_code  (char_code),
        .glyph_row  (glyph_row),
        .glyph_col  (glyph_col),
        .cursor_hit (cursor_hit),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    logic [BW-1:0] bcnt = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) bcnt <= '0;
        else     bcnt <= bcnt + 1'b1;
    end

    typedef struct {
        string    name;
        logic [6:0] code;
        logic [2:0] grow;
        logic [2:0] gcol;
        logic       hit;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic probe   = 1'b0;
    logic probe_d = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(posedge clk) probe_d <= probe;

    always @(negedge clk) begin
        if (probe_d) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_code"}, 32'(char_code), 32'(mon_e.code));
                check({mon_e.name, "_grow"}, 32'(glyph_row), 32'(mon_e.grow));
                check({mon_e.name, "_gcol"}, 32'(glyph_col), 32'(mon_e.gcol));
                check({mon_e.name, "_hit"}, 32'(cursor_hit), 32'(mon_e.hit));
            end
        end
    end

    // Drive a pixel and queue what the DUT must show one cycle later.
    task automatic probe_set(input string name, input int x, input int y, input logic [6:0] code,
                             input int cc, input int cr, input bit idle);
        exp_t e;
        bit   inr;
        inr      = (x < 320) && (y < 240);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        e.name   = name;
        e.code   = inr ? code : 7'h20;
        e.grow   = 3'(y);
        e.gcol   = 3'(x);
        e.hit    = idle && inr && (x / 8 == cc) && (y / 8 == cr) && bcnt[BW-1];
        sb.push_back(e);
        probe = 1'b1;
    endtask

    task automatic do_probe(input string name, input int x, input int y, input logic [6:0] code,
                            input int cc, input int cr, input bit idle);
        probe_set(name, x, y, code, cc, cr, idle);
        @(negedge clk);
        probe = 1'b0;
    endtask

    task automatic send(input logic [7:0] c);
        bus.in_valid = 1'b1;
        bus.in_char  = c;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_cursor(input string name, input int cc, input int cr);
        check({name, "_col"}, 32'(cursor_col), 32'(cc));
        check({name, "_row"}, 32'(cursor_row), 32'(cr));
    endtask

    task automatic wait_ready(input int unsigned t0, input string name);
        int k = 0;
        while (bus.in_ready !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check(name, cyc - t0, 32'd1200);
    endtask

    task automatic sweep_blank(input string name, input int cc, input int cr);
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 40; c++)
                do_probe(name, c * 8 + (r % 8), r * 8 + (c % 8), 7'h20, cc, cr, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    int unsigned t0;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_code", 32'(char_code), 32'h20);
        check("rst_grow", 32'(glyph_row), 32'd0);
        check("rst_gcol", 32'(glyph_col), 32'd0);
        check("rst_hit", 32'(cursor_hit), 32'd0);
        check_cursor("rst_cur", 0, 0);
        t0  = cyc;
        rst = 1'b0;
        wait_ready(t0, "clear_len");
        check("idle_busy", 32'(busy), 32'd0);

        sweep_blank("blank", 0, 0);
        do_probe("x320", 320, 5, 7'h20, 0, 0, 1'b1);
        do_probe("y240", 5, 240, 7'h20, 0, 0, 1'b1);
        do_probe("edge", 319, 239, 7'h20, 0, 0, 1'b1);

        send(8'h41);
        send(8'h42);
        check_cursor("ab_cur", 2, 0);
        do_probe("cell_a", 0, 0, 7'h41, 2, 0, 1'b1);
        do_probe("cell_b", 8, 0, 7'h42, 2, 0, 1'b1);
        do_probe("gcol5", 13, 3, 7'h42, 2, 0, 1'b1);

        for (int c = 2; c < 39; c++) send(8'(8'h30 + c));
        check_cursor("col39", 39, 0);
        send(8'h57);
        check_cursor("wrap_col", 0, 1);
        do_probe("cell39", 312, 7, 7'h57, 0, 1, 1'b1);
        do_probe("cell2", 16, 0, 7'h32, 0, 1, 1'b1);

        for (int i = 0; i < 28; i++) send(8'h0a);
        check_cursor("lf_row29", 0, 29);
        send(8'h0a);
        check_cursor("lf_wrap", 0, 0);

        send(8'h08);
        check_cursor("bs_col0", 0, 0);
        do_probe("bs_nowrite", 0, 0, 7'h41, 0, 0, 1'b1);
        send(8'h58);
        check_cursor("x_cur", 1, 0);
        do_probe("cell_x", 0, 0, 7'h58, 1, 0, 1'b1);
        send(8'h08);
        check_cursor("bs_cur", 0, 0);
        do_probe("bs_erase", 0, 0, 7'h20, 0, 0, 1'b1);
        do_probe("bs_keep", 8, 0, 7'h42, 0, 0, 1'b1);

        send(8'h51);
        send(8'h0d);
        check_cursor("cr_cur", 0, 0);
        send(8'h07);
        check_cursor("other_cur", 0, 0);
        check("other_ready", 32'(bus.in_ready), 32'd1);
        do_probe("cell_q", 0, 0, 7'h51, 0, 0, 1'b1);

        // Same-cell write and read in one cycle.
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h5a;
        probe_set("rdw_old", 0, 0, 7'h51, 0, 0, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        probe = 1'b0;
        do_probe("rdw_new", 0, 0, 7'h5a, 1, 0, 1'b1);
        check_cursor("rdw_cur", 1, 0);

        send(8'h0c);
        t0 = cyc;
        check("ff_busy", 32'(busy), 32'd1);
        check("ff_ready", 32'(bus.in_ready), 32'd0);
        check_cursor("ff_cur", 0, 0);
        @(negedge clk);
        for (int i = 0; i < 300; i++) do_probe("clr_hit", 3, 2, 7'h20, 0, 0, 1'b0);
        wait_ready(t0, "ff_clear_len");
        sweep_blank("ff_blank", 0, 0);

        send(8'h4d);
        send(8'h0c);
        repeat (599) @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h4b;
        @(negedge clk);
        t0  = cyc;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd1);
        check_cursor("rst_mid_cur", 0, 0);
        wait_ready(t0, "rst_clear_len");
        check_cursor("rst_done_cur", 0, 0);
        do_probe("rst_cell0", 0, 0, 7'h20, 0, 0, 1'b1);

        send(8'h0a);
        send(8'h0a);
        send(8'h61);
        send(8'h62);
        send(8'h63);
        check_cursor("blink_cur", 3, 2);
        do_probe("cell_c", 16, 16, 7'h63, 3, 2, 1'b1);
        for (int i = 0; i < 520; i++) begin
            case (i % 4)
                2:       do_probe("nb_right", 32 + i % 8, 16 + (i / 8) % 8, 7'h20, 3, 2, 1'b1);
                3:       do_probe("nb_above", 24 + i % 8, 8 + (i / 8) % 8, 7'h20, 3, 2, 1'b1);
                default: do_probe("blink", 24 + i % 8, 16 + (i / 8) % 8, 7'h20, 3, 2, 1'b1);
            endcase
        end

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
